simd_frame_loader: RTL
======================

Name: simd_frame_loader

Overview:
- Control/framing stage directly upstream and downstream of the 4-lane SIMD datapath (SIPO -> ALU -> PISO lanes).
- Takes a byte stream from the SPI slave source interface, parses a header plus bw operand bytes, and drives the lanes' load/data_in/mode/dtype/send.
- Captures the lanes' 4-bit serial result stream, packs it into bytes, and returns them on the SPI slave sink interface.

Parameters:
- bw, 32, operand/result width per lane in bits; even, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  SPI source byte valid.
- in_data  input  8  SPI source byte.
- in_ready  output  1  byte accepted on an edge where in_valid && in_ready.
- load  output  1  lane shift strobe (to SIPO load).
- lane_bits  output  8  bit k feeds SIPO data_in[k].
- mode  output  4  ALU opcode, held from header.
- dtype  output  1  ALU data type, held from header.
- send  output  1  one-cycle PISO parallel-load strobe.
- res_bits  input  4  PISO serial outputs, lanes 0..3.
- out_valid  output  1  result byte valid.
- out_data  output  8  result byte.
- out_ready  input  1  sink accepts on out_valid && out_ready.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, all counters 0. Outputs: in_ready=0, load=0, lane_bits=0, mode=0, dtype=0, send=0, out_valid=0, out_data=0, busy=0. Reset aborts any frame mid-operation; no partial output bytes are emitted afterwards.
- Frame format: header byte, then bw operand bytes.
  - Header: bit7=1 (start marker), bit4=dtype, bits3:0=mode; bits6:5 ignored.
  - Operand byte j (j=0..bw-1) carries bit j of the serial stream for all 8 operands, MSB-first (j=0 is operand bit bw-1).
- IDLE:
  - in_ready=1.
  - Accepted byte with bit7=0: discarded, stay IDLE.
  - Accepted byte with bit7=1: register mode/dtype, go to LOAD with byte count=0.
- LOAD:
  - in_ready=1.
  - Each accepted byte at edge k: lane_bits=byte and load=1 during cycle k+1 only. load=0 on cycles with no accept.
  - Header-like bytes are data here (no resync).
  - On the accept of byte bw-1: go to SETTLE. in_ready=0 from that cycle on.
- SETTLE: one cycle; carries the final load pulse; send=0.
- SEND: one cycle; send=1, load=0. lane_bits holds its last value.
- CAPTURE: bw cycles, starting the cycle after SEND.
  - res_bits is sampled on each edge. Nibble n (n=0..bw-1) is lane bits {3,2,1,0} = res_bits.
  - Nibbles are packed two per byte into an internal 4*bw-bit buffer: even n -> out byte [7:4], odd n -> [3:0].
  - After the bw-th sample, go to EMIT.
- EMIT:
  - Present bytes 0..bw/2-1 in order. out_valid=1 with out_data stable until accepted.
  - Next byte appears the cycle after a handshake.
  - After the last handshake: out_valid=0, go to IDLE; in_ready=1 the following cycle.
  - out_ready held low stalls indefinitely with no data loss.
- mode and dtype change only on a header accept in IDLE, and stay stable through the whole frame and after it.
- in_valid gaps in LOAD are allowed: no timeout, and load pulses only on accepts.
- Minimum frame turnaround, with in_valid and out_ready held high: 1 + bw + 1 + 1 + bw + bw/2 cycles.

Test Plan:
- Reset mid-LOAD (after 10 of 32 operand bytes): rst=0 for one cycle -> all outputs 0, busy=0. A new header plus 32 bytes then runs a clean full frame with no residue.
- Basic frame, bw=32: header 0x93 (dtype=1, mode=3), then 32 bytes 0xA5 -> mode=3 and dtype=1 one cycle after the header accept. Exactly 32 single-cycle load pulses with lane_bits=0xA5. send=1 exactly two cycles after the last accept.
- Capture/pack: drive res_bits=0xC on the first CAPTURE cycle, 0x3 on the second, then alternating -> 16 out bytes, every byte 0xC3. out_valid drops after byte 16 and busy=0.
- Leading junk: bytes 0x12, 0x7F, then header 0x85 -> junk dropped with no load pulse, mode=5, dtype=0. A later 0x80 inside the operand stream is treated as data (lane_bits=0x80).
- Backpressure: out_ready low for 20 cycles, then toggling every cycle during EMIT -> out_data stable while out_valid && !out_ready. All 16 bytes delivered once, in order; in_ready stays 0 until EMIT completes.
- Input gaps: in_valid toggling every 3 cycles during LOAD -> load count = 32, each pulse exactly one cycle. send timing is relative to the last accept only.

Source files
------------

// File: rtl/simd_frame_loader.sv
// Framing stage around the 4-lane SIMD datapath: parses header plus
// operand bytes into lane shift strobes, then packs serial results back into bytes.
module simd_frame_loader #(
  parameter int bw = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       load,
  output logic [7:0] lane_bits,
  output logic [3:0] mode,
  output logic       dtype,
  output logic       send,
  input  logic [3:0] res_bits,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  localparam int CW = $clog2(bw);
  localparam int BB = 4 * bw;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SEND,
    CAPTURE,
    EMIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_q, load_d;
  logic [7:0]      lane_q, lane_d;
  logic [3:0]      mode_q, mode_d;
  logic            dtype_q, dtype_d;
  logic            rdy_q, rdy_d;
  logic [BB-1:0]   buf_q, buf_d;
  logic            in_acc;

  assign in_acc = in_valid && rdy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      lane_q  <= 8'h00;
      mode_q  <= 4'h0;
      dtype_q <= 1'b0;
      rdy_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      lane_q  <= lane_d;
      mode_q  <= mode_d;
      dtype_q <= dtype_d;
      rdy_q   <= rdy_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    lane_d  = lane_q;
    mode_d  = mode_q;
    dtype_d = dtype_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (in_acc && in_data[7]) begin
          mode_d  = in_data[3:0];
          dtype_d = in_data[4];
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_acc) begin
          load_d = 1'b1;
          lane_d = in_data;
          if (cnt_q == CW'(bw - 1)) begin
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SETTLE: state_d = SEND;
      SEND: begin
        cnt_d   = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // nibble 0 ends up in the top of the buffer
        buf_d = {buf_q[BB-5:0], res_bits};
        if (cnt_q == CW'(bw - 1)) begin
          cnt_d   = '0;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          buf_d = buf_q << 8;
          if (cnt_q == CW'(bw / 2 - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE) || (state_d == LOAD);
  end

  assign in_ready  = rdy_q;
  assign load      = load_q;
  assign lane_bits = lane_q;
  assign mode      = mode_q;
  assign dtype     = dtype_q;
  assign send      = (state_q == SEND);
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? buf_q[BB-1 -: 8] : 8'h00;
  assign busy      = (state_q != IDLE);

endmodule
